timer_counter: RTL
==================

# timer_counter

Memory-mapped countdown timer (TC0) on the peripheral side of the system bridge. It sits downstream of the bridge, which forwards the full data address, a word write enable and write data, and returns `Dout` on reads. It counts down from a software-programmed preset. At terminal count it raises an interrupt request to the CPU's exception logic, either one-shot (mode 0) or auto-reload (mode 1).

## Interface
Parameters:
- none (register map and widths are fixed)

Ports:
- `clk`  in  1  system clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `Addr`  in  32  byte address from bridge; only `Addr[3:2]` decoded (bridge guarantees the TC0 window 0x7f00–0x7f0b)
- `WE`  in  1  word write strobe, already qualified by the bridge's TC0 select
- `Din`  in  32  write data
- `Dout`  out  32  read data, combinational from `Addr[3:2]` and current registers
- `IRQ`  out  1  interrupt request = `ctrl[3] & irq_flag`

## Operation
- Register map by `Addr[3:2]`:
  - 0 = CTRL (R/W): bit0 Enable, bits2:1 Mode, bit3 IM; reads `{28'b0, ctrl[3:0]}`
  - 1 = PRESET (R/W, 32 bit)
  - 2 = COUNT (read-only; writes ignored)
  - 3 reads 0; writes ignored
- Write to CTRL stores `Din[3:0]` and clears `irq_flag`.
- Mode encoding: 00 = one-shot; 01 = auto-reload; 10 and 11 behave as 00.
- FSM states and transitions:
  - IDLE: go to LOAD when Enable=1.
  - LOAD: `count <= preset`; go to CNT.
  - CNT:
    - Enable=0: go to IDLE; count holds.
    - count > 1: `count <= count - 1`.
    - count ≤ 1: `count <= 0`; set `irq_flag`; go to INT.
  - INT: go to IDLE.
    - Mode 0: clear Enable; `irq_flag` stays set until the next CTRL write.
    - Mode 1: clear `irq_flag`; Enable is kept, so the timer reloads.
- Unsigned arithmetic; count never wraps below 0.
- Preset 0 behaves like preset 1.
- Simultaneous events:
  - A CTRL write on the same edge as an FSM-driven Enable clear or `irq_flag` set wins. Stored value = `Din[3:0]`, `irq_flag` = 0.
  - A PRESET write during CNT does not affect the running count; it is used at the next LOAD.
  - A CTRL write that clears Enable during LOAD still completes the load, then CNT exits to IDLE on the following edge.
- Reset mid-operation: everything returns to reset values on the next edge, regardless of state.

## Timing
- Reset values: state IDLE, ctrl 0, preset 0, count 0, `irq_flag` 0, `IRQ` 0. `Dout` follows the reset registers (0 for all addresses).
- Register writes take effect at the edge where `WE=1`; readable in the following cycle.
- From the edge that writes Enable=1, with preset N ≥ 1:
  - LOAD after 1 edge.
  - CNT with count=N after 2 edges.
  - count reaches 0 and `irq_flag` sets after N+2 edges.
  - INT → IDLE after N+3 edges.
- Mode 1 period: N+3 cycles; `IRQ` is high for exactly 1 cycle per period when IM=1.
- Mode 0: `IRQ` stays high (IM=1) until a CTRL write.
- `IRQ` is purely registered-state derived: no combinational path from `WE`/`Din`.

## Test plan
- Reset: assert `reset` 2 cycles mid-count → `Dout` for addr 0/4/8 = 0, `IRQ`=0, no counting afterwards.
- One-shot:
  - Stimulus: PRESET=5, then CTRL=0x9 (IM, mode 0, enable).
  - Required: COUNT reads 5,4,3,2,1,0 on consecutive cycles after LOAD; `IRQ` rises 7 edges after the CTRL write and stays high; CTRL reads 0x8.
  - Then write CTRL=0x8 → `IRQ` falls next cycle.
- Auto-reload: PRESET=3, CTRL=0xB → `IRQ` 1-cycle pulses every 6 cycles for at least 4 periods; Enable stays 1.
- Mask: PRESET=2, CTRL=0x1 → count reaches 0 and Enable clears, `IRQ` never asserts. A following write of 0x8 leaves `IRQ`=0 because the flag is cleared.
- Mid-count changes:
  - Stimulus: disable via CTRL=0x0 while count=10.
  - Required: count freezes at its value; re-enable → reload from PRESET, not resume.
  - Stimulus: PRESET written during CNT.
  - Required: current run unaffected; new value used on the next reload.
- Collision and decode:
  - CTRL write on the same edge `irq_flag` would set → `IRQ` stays 0.
  - Writes to addr 8 and 0xC → no register changes; addr 0xC reads 0.

Source files
------------

// File: rtl/timer_counter.sv
// TC0 countdown timer: CTRL/PRESET/COUNT registers behind the bridge, one-shot or
// auto-reload terminal-count interrupt.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_CNT  = 2'd2,
        S_INT  = 2'd3
    } state_e;

    state_e      state_q;
    logic [3:0]  ctrl_q;
    logic [31:0] preset_q;
    logic [31:0] count_q;
    logic        irq_flag_q;
    logic [31:0] count_dec_d;
    logic        auto_reload;
    logic        unused_addr;

    assign count_dec_d = count_q - 32'd1;
    assign auto_reload = (ctrl_q[2:1] == 2'b01);
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            preset_q   <= '0;
            count_q    <= '0;
            irq_flag_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ctrl_q[0]) state_q <= S_LOAD;
                end
                S_LOAD: begin
                    count_q <= preset_q;
                    state_q <= S_CNT;
                end
                S_CNT: begin
                    if (!ctrl_q[0]) begin
                        state_q <= S_IDLE;
                    end else if (count_q > 32'd1) begin
                        count_q <= count_dec_d;
                    end else begin
                        count_q    <= '0;
                        irq_flag_q <= 1'b1;
                        state_q    <= S_INT;
                    end
                end
                S_INT: begin
                    state_q <= S_IDLE;
                    if (auto_reload) irq_flag_q <= 1'b0;
                    else             ctrl_q[0]  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase

            // Bus writes come last so a CTRL write overrides FSM updates on the same edge.
            if (WE) begin
                case (Addr[3:2])
                    2'd0: begin
                        ctrl_q     <= Din[3:0];
                        irq_flag_q <= 1'b0;
                    end
                    2'd1:    preset_q <= Din;
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            2'd0:    Dout = {28'd0, ctrl_q};
            2'd1:    Dout = preset_q;
            2'd2:    Dout = count_q;
            default: Dout = '0;
        endcase
    end

    assign IRQ = ctrl_q[3] & irq_flag_q;

endmodule
